// File: rtl/apb_slv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_slv_pkg
// Brief    : Shared types and constants for the parametrised APB4 register bank.
// Revision : 1.0
// ============================================================================
package apb_slv_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam int WAIT_W = 4;

    // Number of PADDR bits that select a byte within one data word.
    function automatic int byte_offs(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_slv_regfile.sv
`default_nettype none
// ============================================================================
// Module   : apb_slv_regfile
// Brief    : NUM_REGS x DATA_WIDTH storage, byte-enabled write port, async read.
// Revision : 1.0
// ============================================================================
module apb_slv_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 64,
    parameter int IDX_W      = 7
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_we,
    input  logic [IDX_W-1:0]        i_waddr,
    input  logic [DATA_WIDTH/8-1:0] i_wbe,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [IDX_W-1:0]        i_raddr,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    localparam int c_NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i_waddr == IDX_W'(i)) begin
                    for (int b = 0; b < c_NBYTES; b++) begin
                        if (i_wbe[b]) begin
                            r_mem[i][b*8 +: 8] <= i_wdata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Decoded mux keeps out-of-range indices reading as zero.
    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_raddr == IDX_W'(i)) begin
                o_rdata = r_mem[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_slave_regbank.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_regbank
// Brief    : APB4 slave register bank with wait states, byte strobes (when
//            APB_SLV_PSTRB_EN is defined) and rule-driven PSLVERR.
// Revision : 1.0
// ============================================================================
module apb_slave_regbank
    import apb_slv_pkg::*;
#(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int c_BOFFS  = byte_offs(DATA_WIDTH);
    localparam int c_IDX_W  = ADDR_WIDTH - c_BOFFS;
    localparam int c_NBYTES = DATA_WIDTH / 8;
    localparam logic [c_IDX_W:0] c_NUM_REGS = (c_IDX_W + 1)'(NUM_REGS);

    state_e                r_state;
    state_e                w_next_state;
    logic [WAIT_W-1:0]     r_cnt;
    logic                  r_write;
    logic                  r_err;
    logic [c_IDX_W-1:0]    r_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [c_NBYTES-1:0]   w_wbe;
    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_misalign;
    logic                  w_err;
    logic                  w_ready;
    logic                  w_setup;
    logic                  w_complete;
    logic                  w_we;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_idx = PADDR[ADDR_WIDTH-1:c_BOFFS];

    generate
        if (c_BOFFS > 0) begin : g_offs
            assign w_misalign = |PADDR[c_BOFFS-1:0];
        end else begin : g_no_offs
            assign w_misalign = 1'b0;
        end
    endgenerate

    assign w_err   = w_misalign | ({1'b0, w_idx} >= c_NUM_REGS);
    assign w_ready = (r_cnt == '0);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_setup      = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_setup      = 1'b1;
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                // Dropping PSEL abandons the transfer without a commit.
                if (!PSEL) begin
                    w_next_state = IDLE;
                end else if (PENABLE && w_ready) begin
                    w_complete   = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Transfer fields are frozen at setup; the bus is ignored during waits.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else if (w_setup) begin
            r_cnt   <= WAIT_W'(WAIT_STATES);
            r_write <= PWRITE;
            r_err   <= w_err;
            r_idx   <= w_idx;
            r_wdata <= PWDATA;
        end else if (r_state == ACCESS && !w_ready) begin
            r_cnt   <= r_cnt - 1'b1;
        end
    end

`ifdef APB_SLV_PSTRB_EN
    logic [c_NBYTES-1:0] r_strb;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_strb <= '0;
        end else if (w_setup) begin
            r_strb <= PSTRB;
        end
    end

    assign w_wbe = r_strb;
`else
    logic w_unused_strb;

    assign w_unused_strb = ^PSTRB;
    assign w_wbe         = '1;
`endif

    assign w_we = w_complete & r_write & ~r_err;

    apb_slv_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (c_IDX_W)
    ) u_regfile (
        .i_clk   (PCLK),
        .i_rst_n (PRESETn),
        .i_we    (w_we),
        .i_waddr (r_idx),
        .i_wbe   (w_wbe),
        .i_wdata (r_wdata),
        .i_raddr (r_idx),
        .o_rdata (w_rdata)
    );

    assign PREADY  = w_complete;
    assign PSLVERR = w_complete & r_err;
    assign PRDATA  = (w_complete && !r_write && !r_err) ? w_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regbank.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_slave_regbank
// Brief    : Directed bench for apb_slave_regbank, zero and three wait states.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_apb_slave_regbank;

    logic        PCLK    = 1'b0;
    logic        PRESETn = 1'b0;
    logic        psel    = 1'b0;
    logic        dsel    = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE  = 1'b0;
    logic [8:0]  PADDR   = '0;
    logic [31:0] PWDATA  = '0;
    logic [3:0]  PSTRB   = '0;

    logic        psel0, psel3;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3, pslverr0, pslverr3;
    logic [31:0] s_prdata;
    logic        s_pready, s_pslverr;

    int checks = 0;
    int fails  = 0;

    always #5 PCLK = ~PCLK;

    assign psel0     = psel & ~dsel;
    assign psel3     = psel &  dsel;
    assign s_prdata  = dsel ? prdata3  : prdata0;
    assign s_pready  = dsel ? pready3  : pready0;
    assign s_pslverr = dsel ? pslverr3 : pslverr0;

    apb_slave_regbank #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .NUM_REGS(64), .WAIT_STATES(0)) u_dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel0), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
    );

    apb_slave_regbank #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .NUM_REGS(64), .WAIT_STATES(3)) u_dut3 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel3), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
    );

`ifdef APB_SLV_PSTRB_EN
    localparam logic [31:0] EXP_STRB_WORD = 32'h11BB33DD;
`else
    localparam logic [31:0] EXP_STRB_WORD = 32'hAABBCCDD;
`endif

    typedef struct {
        bit          d;
        bit          wr;
        logic [8:0]  a;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_waits;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Entered and left one time unit after a rising edge.
    task automatic xfer(input bit d, input bit wr, input logic [8:0] a, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd, output logic err,
                        output int waits);
        bit done;
        dsel = d; psel = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd; PSTRB = st;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1;
        waits = 0; done = 1'b0; rd = '0; err = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            if (s_pready === 1'b1) begin
                rd = s_prdata; err = s_pslverr; done = 1'b1;
            end else begin
                waits++;
                @(posedge PCLK); #2;
            end
        end
        if (!done) begin
            checks++; fails++;
            $display("FAIL xfer_timeout: no PREADY at addr 0x%03h, required within 40 cycles", a);
        end
        @(posedge PCLK); #1;
        psel = 1'b0; PENABLE = 1'b0;
    endtask

    logic [31:0] rd;
    logic        err;
    int          waits;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0, 1, 9'h010, 32'hDEADBEEF, 4'hF, 32'h0,         1'b0, 0};
        vecs[1]  = '{0, 0, 9'h010, 32'h0,        4'h0, 32'hDEADBEEF,  1'b0, 0};
        vecs[2]  = '{0, 1, 9'h020, 32'h11223344, 4'hF, 32'h0,         1'b0, 0};
        vecs[3]  = '{0, 1, 9'h020, 32'hAABBCCDD, 4'h5, 32'h0,         1'b0, 0};
        vecs[4]  = '{0, 0, 9'h020, 32'h0,        4'h0, EXP_STRB_WORD, 1'b0, 0};
        vecs[5]  = '{0, 1, 9'h100, 32'hFFFFFFFF, 4'hF, 32'h0,         1'b1, 0};
        vecs[6]  = '{0, 1, 9'h013, 32'hFFFFFFFF, 4'hF, 32'h0,         1'b1, 0};
        vecs[7]  = '{0, 0, 9'h000, 32'h0,        4'h0, 32'h0,         1'b0, 0};
        vecs[8]  = '{0, 0, 9'h010, 32'h0,        4'h0, 32'hDEADBEEF,  1'b0, 0};
        vecs[9]  = '{0, 0, 9'h1FC, 32'h0,        4'h0, 32'h0,         1'b1, 0};
        vecs[10] = '{0, 0, 9'h011, 32'h0,        4'h0, 32'h0,         1'b1, 0};
        vecs[11] = '{0, 0, 9'h0FC, 32'h0,        4'hF, 32'h0,         1'b0, 0};
        vecs[12] = '{0, 1, 9'h0FC, 32'h12345678, 4'hF, 32'h0,         1'b0, 0};
        vecs[13] = '{0, 0, 9'h0FC, 32'h0,        4'h0, 32'h12345678,  1'b0, 0};
        vecs[14] = '{1, 1, 9'h030, 32'hCAFEF00D, 4'hF, 32'h0,         1'b0, 3};
        vecs[15] = '{1, 0, 9'h030, 32'h0,        4'h0, 32'hCAFEF00D,  1'b0, 3};

        // Reset state
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_pready0",  {31'b0, pready0},  32'h0);
        chk("rst_pslverr0", {31'b0, pslverr0}, 32'h0);
        chk("rst_prdata0",  prdata0,           32'h0);
        chk("rst_pready3",  {31'b0, pready3},  32'h0);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        for (int i = 0; i < 16; i++) begin
            xfer(vecs[i].d, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].st, rd, err, waits);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
            chk($sformatf("vec%0d_waits", i), waits, vecs[i].exp_waits);
        end

        // Wait-state read with the bus toggling during the waits
        dsel = 1'b1; psel = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 9'h030; PSTRB = 4'h0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            PADDR  = (i % 2 == 1) ? 9'h013 : 9'h100;
            PWRITE = 1'b1;
            PWDATA = $urandom;
            PSTRB  = 4'hF;
            #1;
            chk($sformatf("ws3_wait%0d_pready", i), {31'b0, pready3}, 32'h0);
            chk($sformatf("ws3_wait%0d_prdata", i), prdata3, 32'h0);
            @(posedge PCLK); #1;
        end
        PADDR = 9'h1FC;
        #1;
        chk("ws3_done_pready",  {31'b0, pready3},  32'h1);
        chk("ws3_done_prdata",  prdata3,           32'hCAFEF00D);
        chk("ws3_done_pslverr", {31'b0, pslverr3}, 32'h0);
        @(posedge PCLK); #1;
        psel = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        xfer(1, 0, 9'h030, 32'h0, 4'h0, rd, err, waits);
        chk("ws3_reread", rd, 32'hCAFEF00D);

        // Master abort of a write
        xfer(0, 1, 9'h008, 32'h01020304, 4'hF, rd, err, waits);
        dsel = 1'b0; psel = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 9'h008;
        PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        psel = 1'b0;
        #1;
        chk("abort_pready",  {31'b0, pready0},  32'h0);
        chk("abort_pslverr", {31'b0, pslverr0}, 32'h0);
        @(posedge PCLK); #1;
        xfer(0, 0, 9'h008, 32'h0, 4'h0, rd, err, waits);
        chk("abort_rdata", rd, 32'h01020304);
        chk("abort_err", {31'b0, err}, 32'h0);
        chk("abort_waits", waits, 0);

        // Reset during a completing read: outputs drop without a clock edge
        dsel = 1'b0; psel = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 9'h010;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1;
        chk("prerst_pready0", {31'b0, pready0}, 32'h1);
        chk("prerst_prdata0", prdata0, 32'hDEADBEEF);
        PRESETn = 1'b0;
        #1;
        chk("midrst_pready0", {31'b0, pready0}, 32'h0);
        chk("midrst_prdata0", prdata0, 32'h0);
        psel = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // Reset during a wait state of a write
        dsel = 1'b1; psel = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 9'h004;
        PWDATA = 32'h55AA55AA; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESETn = 1'b0;
        #1;
        chk("wrst_pready3",  {31'b0, pready3},  32'h0);
        chk("wrst_pslverr3", {31'b0, pslverr3}, 32'h0);
        chk("wrst_prdata3",  prdata3,           32'h0);
        psel = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        xfer(1, 0, 9'h004, 32'h0, 4'h0, rd, err, waits);
        chk("postrst_0x004", rd, 32'h0);
        chk("postrst_0x004_err", {31'b0, err}, 32'h0);
        xfer(1, 0, 9'h030, 32'h0, 4'h0, rd, err, waits);
        chk("postrst_dut3_0x030", rd, 32'h0);
        xfer(0, 0, 9'h010, 32'h0, 4'h0, rd, err, waits);
        chk("postrst_dut0_0x010", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
